uart_rom_loader: RTL and testbench
==================================

// Module: uart_rom_loader
// PURPOSE
//  UART 8N1 receiver that loads a program image into instruction ROM over uart_rx. It is the
//  writer side of the ROM, whose reader is the CPU fetch port.
//  Bytes are assembled little-endian into 32-bit words and written at consecutive addresses
//  from 0. Loading ends on the halt word (32'h0000_000A), which is written. cpu_hold keeps the
//  CPU in reset until loading is done.
// PARAMETERS
//  WAIT       8            clk cycles per UART bit; legal range >= 4
//  ADDR_W     8            ROM word-address width
//  HALT_WORD  32'h0000000A word that terminates loading; it is written before stopping
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low reset
//  uart_rx    in   1       serial input, idle high; asynchronous to clk
//  rom_we     out  1       one-cycle ROM write strobe
//  rom_addr   out  ADDR_W  word address for rom_we
//  rom_wdata  out  32      word for rom_we
//  cpu_hold   out  1       1 while loading; CPU held in reset
//  done       out  1       sticky 1 once loading has ended
//  frame_err  out  1       sticky 1 after any stop bit sampled low
// BEHAVIOUR
//  Reset (reset==0, async): FSM=IDLE; rom_we=0; rom_addr=0; rom_wdata=0; cpu_hold=1; done=0;
//   frame_err=0; byte_cnt=0; bit counters=0; rx synchroniser flops preset to 1.
//  uart_rx passes through a 2-FF synchroniser (rxs). All decisions use rxs only.
//  FSM states and transitions:
//   IDLE:  on rxs==0, clear the cycle counter and go to START.
//   START: after WAIT/2 cycles, sample rxs. If 1 (glitch), go to IDLE. If 0, go to DATA with bit=0.
//   DATA:  every WAIT cycles, sample rxs into shift[bit], LSB first. After bit 7, go to STOP.
//   STOP:  after WAIT cycles, sample rxs.
//          1: byte valid; go to IDLE.
//          0: set frame_err, discard the byte, leave byte_cnt unchanged; go to IDLE once rxs==1.
//   DONE:  terminal state; uart_rx is ignored until reset.
//  Word assembly: valid byte k (byte_cnt = 0..3) is placed in word[8k+7:8k], then byte_cnt++.
//  Write timing: on the 4th valid byte, rom_we=1 in the next cycle, for exactly 1 cycle, with
//   rom_wdata = the assembled word and rom_addr = the current address. rom_addr increments the
//   cycle after rom_we. byte_cnt wraps to 0.
//  Termination: the word written equals HALT_WORD, OR it is written at address 2**ADDR_W-1.
//   In either case, in the cycle after rom_we: done=1, cpu_hold=0, FSM=DONE.
//   rom_addr stays at the last written address (no wrap-around).
//  A partial word (byte_cnt != 0) is never written.
//  Reset mid-byte or mid-word discards all partial state. Writes already made are not undone.
//  Sample point: the middle of each bit, i.e. WAIT/2 + n*WAIT cycles after the start edge is
//   seen on rxs.
//  Frame time is 10*WAIT cycles. A new start bit is accepted from IDLE on the cycle after STOP.
// TESTING
//  T1: WAIT=8. Send bytes 01 10 00 00 then 0A 00 00 00.
//      -> rom_we @addr0 = 32'h00001001; rom_we @addr1 = 32'h0000000A;
//         then done=1 and cpu_hold=0; further bytes produce no rom_we.
//  T2: Send 3 bytes, pull reset low, then send a full halt word.
//      -> single rom_we @addr0 = 32'h0000000A; no write is made from the partial word.
//  T3: Send a 4-cycle low glitch on uart_rx.
//      -> FSM returns to IDLE; no byte counted; frame_err=0.
//  T4: Send byte 55 with its stop bit held 0, then a halt word.
//      -> frame_err=1; byte 55 dropped; rom_we @addr0 = 32'h0000000A.
//  T5: ADDR_W=2. Send 4 non-halt words.
//      -> writes at addr 0..3; done=1 after addr 3; rom_addr stays 3.
//  T6: Loader writes 3 words (addi x2=3; addi x3=x2+1; halt), then the CPU runs.
//      -> CPU register x[3]==4.

Source files
------------

// File: rtl/uart_rom_loader_if.sv
// ROM write port of the UART program loader.
// The loader drives it (master) and the instruction ROM write side receives it (slave).
interface uart_rom_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;

    modport master (
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    modport slave (
        input rom_we,
        input rom_addr,
        input rom_wdata
    );
endinterface

// File: rtl/uart_rom_loader.sv
// UART 8N1 receiver that assembles a little-endian program image into 32-bit words.
// Each word is written to instruction ROM at consecutive addresses starting from 0.
// The CPU is held in reset until either the halt word is written or the last ROM address is filled.
module uart_rom_loader #(
    parameter int          WAIT      = 8,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'h0000_000A
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rx,
    uart_rom_loader_if.master  rom,
    output logic               cpu_hold,
    output logic               done,
    output logic               frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int            CW        = $clog2(WAIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(WAIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // A write ends loading if it carries the halt word or it fills the top ROM address.
    function automatic logic is_last_word(input logic [31:0] data, input logic [ADDR_W-1:0] addr);
        return (data == HALT_WORD) || (addr == {ADDR_W{1'b1}});
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic              rx_meta_r;
    logic              rx_sync_r;
    logic [CW-1:0]     cyc_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic [23:0]       word_r;
    logic [1:0]        byte_cnt_r;
    logic              rom_we_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [31:0]       rom_wdata_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              frame_err_r;

    logic              cnt_clr_s;
    logic              bit_clr_s;
    logic              data_smp_s;
    logic              byte_ok_s;
    logic              frame_bad_s;
    logic              term_s;

    assign term_s = rom_we_r && is_last_word(rom_wdata_r, rom_addr_r);

    // Two-flop synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and per-cycle datapath strobes; bit sampling happens mid-bit.
    always_comb begin
        state_nx_s  = state_r;
        cnt_clr_s   = 1'b0;
        bit_clr_s   = 1'b0;
        data_smp_s  = 1'b0;
        byte_ok_s   = 1'b0;
        frame_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (term_s) begin
                    state_nx_s = ST_DONE;
                end else if (!rx_sync_r) begin
                    state_nx_s = ST_START;
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cyc_cnt_r == HALF_LAST) begin
                    cnt_clr_s  = 1'b1;
                    bit_clr_s  = 1'b1;
                    state_nx_s = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cnt_clr_s  = 1'b1;
                    data_smp_s = 1'b1;
                    state_nx_s = (bit_cnt_r == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (rx_sync_r) begin
                        byte_ok_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        frame_bad_s = 1'b1;
                        state_nx_s  = ST_BREAK;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                state_nx_s = rx_sync_r ? ST_IDLE : ST_BREAK;
            end
            ST_DONE: begin
                state_nx_s = ST_DONE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period cycle counter, restarted at every sample point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cyc_cnt_r <= '0;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
        end
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else if (bit_clr_s) begin
            bit_cnt_r <= 3'd0;
        end else if (data_smp_s) begin
            shift_r[bit_cnt_r] <= rx_sync_r;
            bit_cnt_r          <= bit_cnt_r + 3'd1;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Little-endian word assembly; the fourth valid byte launches the ROM write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_r      <= 24'h000000;
            byte_cnt_r  <= 2'd0;
            rom_we_r    <= 1'b0;
            rom_wdata_r <= 32'h0000_0000;
        end else if (byte_ok_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
                2'd0: begin
                    word_r[7:0] <= shift_r;
                    rom_we_r    <= 1'b0;
                end
                2'd1: begin
                    word_r[15:8] <= shift_r;
                    rom_we_r     <= 1'b0;
                end
                2'd2: begin
                    word_r[23:16] <= shift_r;
                    rom_we_r      <= 1'b0;
                end
                2'd3: begin
                    rom_we_r    <= 1'b1;
                    rom_wdata_r <= {shift_r, word_r};
                end
                default: begin
                    rom_we_r <= 1'b0;
                end
            endcase
        end else begin
            rom_we_r <= 1'b0;
        end
    end

    // Address advance after each write, frozen on the terminating write; done/hold status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_r <= '0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
        end else if (term_s) begin
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b1;
        end else if (rom_we_r) begin
            rom_addr_r <= rom_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            rom_addr_r <= rom_addr_r;
        end
    end

    // Sticky framing error flag for any stop bit sampled low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_r <= 1'b0;
        end else if (frame_bad_s) begin
            frame_err_r <= 1'b1;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end

    assign rom.rom_we    = rom_we_r;
    assign rom.rom_addr  = rom_addr_r;
    assign rom.rom_wdata = rom_wdata_r;
    assign cpu_hold      = cpu_hold_r;
    assign done          = done_r;
    assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for the UART ROM loader: a main instance (ADDR_W=8) and a small one (ADDR_W=2).
module tb_uart_rom_loader;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    logic hold1, done1, ferr1, hold2, done2, ferr2;

    int tot = 0;
    int bad = 0;

    uart_rom_loader_if #(.ADDR_W(8)) bus1 ();
    uart_rom_loader_if #(.ADDR_W(2)) bus2 ();

    uart_rom_loader #(.WAIT(W), .ADDR_W(8), .HALT_WORD(32'h0000_000A)) dut1 (
        .clk(clk), .reset(rst_n), .uart_rx(rx1), .rom(bus1),
        .cpu_hold(hold1), .done(done1), .frame_err(ferr1)
    );

    uart_rom_loader #(.WAIT(W), .ADDR_W(2), .HALT_WORD(32'h0000_000A)) dut2 (
        .clk(clk), .reset(rst_n), .uart_rx(rx2), .rom(bus2),
        .cpu_hold(hold2), .done(done2), .frame_err(ferr2)
    );

    always #5 clk = ~clk;

    // Write logs {addr, data} and strobe-width monitors.
    logic [39:0] q1[$];
    logic [33:0] q2[$];
    int wide1 = 0;
    int wide2 = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always @(negedge clk) begin
        if (bus1.rom_we) q1.push_back({bus1.rom_addr, bus1.rom_wdata});
        if (bus2.rom_we) q2.push_back({bus2.rom_addr, bus2.rom_wdata});
        if (bus1.rom_we && prev1) wide1 = wide1 + 1;
        if (bus2.rom_we && prev2) wide2 = wide2 + 1;
        prev1 = bus1.rom_we;
        prev2 = bus2.rom_we;
    end

    task automatic drive(input int which, input logic v);
        if (which == 1) rx1 = v; else rx2 = v;
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
        @(posedge clk);
        drive(which, 1'b0);
        repeat (W) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            repeat (W) @(posedge clk);
        end
        drive(which, stop);
        repeat (W) @(posedge clk);
        if (!stop) begin
            drive(which, 1'b1);
            repeat (2 * W) @(posedge clk);
        end
    endtask

    task automatic send_word(input int which, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(which, w[8*i +: 8], 1'b1);
        repeat (2 * W) @(posedge clk);
    endtask

    task automatic do_reset();
        rx1 = 1'b1;
        rx2 = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tot++; if (bus1.rom_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", bus1.rom_we); end
        tot++; if (bus1.rom_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got %h want 00", bus1.rom_addr); end
        tot++; if (bus1.rom_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got %h want 0", bus1.rom_wdata); end
        tot++; if (hold1 !== 1'b1) begin bad++; $display("FAIL reset_hold got %b want 1", hold1); end
        tot++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done1); end
        tot++; if (ferr1 !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", ferr1); end
    endtask

    task automatic test_load();
        int base;
        do_reset();
        base = q1.size();
        send_word(1, 32'h0000_1001);
        tot++; if (hold1 !== 1'b1) begin bad++; $display("FAIL load_hold_mid got %b want 1", hold1); end
        send_word(1, 32'h0000_000A);
        tot++; if (q1.size() - base !== 2) begin bad++; $display("FAIL load_count got %0d want 2", q1.size() - base); end
        if (q1.size() - base >= 2) begin
            tot++; if (q1[base] !== {8'd0, 32'h0000_1001}) begin bad++; $display("FAIL load_w0 got %h want 0000001001", q1[base]); end
            tot++; if (q1[base+1] !== {8'd1, 32'h0000_000A}) begin bad++; $display("FAIL load_w1 got %h want 010000000a", q1[base+1]); end
        end
        tot++; if (done1 !== 1'b1) begin bad++; $display("FAIL load_done got %b want 1", done1); end
        tot++; if (hold1 !== 1'b0) begin bad++; $display("FAIL load_hold got %b want 0", hold1); end
        tot++; if (bus1.rom_addr !== 8'd1) begin bad++; $display("FAIL load_addr got %h want 01", bus1.rom_addr); end
        send_word(1, 32'h0000_000A);
        tot++; if (q1.size() - base !== 2) begin bad++; $display("FAIL load_after_done got %0d want 2", q1.size() - base); end
    endtask

    task automatic test_reset_midword();
        int base;
        do_reset();
        base = q1.size();
        send_byte(1, 8'h11, 1'b1);
        send_byte(1, 8'h22, 1'b1);
        send_byte(1, 8'h33, 1'b1);
        @(posedge clk);
        rx1 = 1'b0;
        repeat (4 * W) @(posedge clk);
        rx1 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(posedge clk);
        send_word(1, 32'h0000_000A);
        tot++; if (q1.size() - base !== 1) begin bad++; $display("FAIL midreset_count got %0d want 1", q1.size() - base); end
        if (q1.size() - base >= 1) begin
            tot++; if (q1[base] !== {8'd0, 32'h0000_000A}) begin bad++; $display("FAIL midreset_w0 got %h want 000000000a", q1[base]); end
        end
        tot++; if (done1 !== 1'b1) begin bad++; $display("FAIL midreset_done got %b want 1", done1); end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = q1.size();
        @(posedge clk);
        rx1 = 1'b0;
        repeat (4) @(posedge clk);
        rx1 = 1'b1;
        repeat (4 * W) @(posedge clk);
        tot++; if (ferr1 !== 1'b0) begin bad++; $display("FAIL glitch_ferr got %b want 0", ferr1); end
        send_word(1, 32'h0000_000A);
        tot++; if (q1.size() - base !== 1) begin bad++; $display("FAIL glitch_count got %0d want 1", q1.size() - base); end
        if (q1.size() - base >= 1) begin
            tot++; if (q1[base] !== {8'd0, 32'h0000_000A}) begin bad++; $display("FAIL glitch_w0 got %h want 000000000a", q1[base]); end
        end
    endtask

    task automatic test_frame_err();
        int base;
        do_reset();
        base = q1.size();
        send_byte(1, 8'h55, 1'b0);
        tot++; if (ferr1 !== 1'b1) begin bad++; $display("FAIL ferr_set got %b want 1", ferr1); end
        send_word(1, 32'h0000_000A);
        tot++; if (ferr1 !== 1'b1) begin bad++; $display("FAIL ferr_sticky got %b want 1", ferr1); end
        tot++; if (q1.size() - base !== 1) begin bad++; $display("FAIL ferr_count got %0d want 1", q1.size() - base); end
        if (q1.size() - base >= 1) begin
            tot++; if (q1[base] !== {8'd0, 32'h0000_000A}) begin bad++; $display("FAIL ferr_w0 got %h want 000000000a", q1[base]); end
        end
    endtask

    task automatic test_addr_limit();
        int base;
        logic [31:0] words [4];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;
        do_reset();
        base = q2.size();
        for (int i = 0; i < 4; i++) send_word(2, words[i]);
        tot++; if (q2.size() - base !== 4) begin bad++; $display("FAIL limit_count got %0d want 4", q2.size() - base); end
        if (q2.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                tot++; if (q2[base+i] !== {2'(i), words[i]}) begin bad++; $display("FAIL limit_w%0d got %h want %h", i, q2[base+i], {2'(i), words[i]}); end
            end
        end
        tot++; if (done2 !== 1'b1) begin bad++; $display("FAIL limit_done got %b want 1", done2); end
        tot++; if (hold2 !== 1'b0) begin bad++; $display("FAIL limit_hold got %b want 0", hold2); end
        tot++; if (bus2.rom_addr !== 2'd3) begin bad++; $display("FAIL limit_addr got %0d want 3", bus2.rom_addr); end
    endtask

    task automatic test_cpu_program();
        int base;
        int pc;
        logic [31:0] rom [8];
        logic [31:0] regs [32];
        logic [31:0] ins;
        for (int i = 0; i < 8; i++) rom[i] = 32'h0000_000A;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        do_reset();
        base = q1.size();
        send_word(1, 32'h0030_0113);
        send_word(1, 32'h0011_0193);
        send_word(1, 32'h0000_000A);
        tot++; if (q1.size() - base !== 3) begin bad++; $display("FAIL cpu_count got %0d want 3", q1.size() - base); end
        for (int i = base; i < q1.size(); i++) begin
            if (q1[i][39:32] < 8'd8) rom[q1[i][34:32]] = q1[i][31:0];
        end
        tot++; if (hold1 !== 1'b0) begin bad++; $display("FAIL cpu_release got %b want 0", hold1); end
        pc = 0;
        while (pc < 8 && rom[pc] !== 32'h0000_000A) begin
            ins = rom[pc];
            if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0 && ins[11:7] != 5'd0)
                regs[ins[11:7]] = regs[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
            pc++;
        end
        tot++; if (regs[3] !== 32'd4) begin bad++; $display("FAIL cpu_x3 got %0d want 4", regs[3]); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reset_midword();
        test_glitch();
        test_frame_err();
        test_addr_limit();
        test_cpu_program();
        tot++; if (wide1 !== 0) begin bad++; $display("FAIL we_width1 got %0d want 0", wide1); end
        tot++; if (wide2 !== 0) begin bad++; $display("FAIL we_width2 got %0d want 0", wide2); end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
